// File: rtl/octavo_io_write_arbiter.sv
`default_nettype none
// ============================================================================
// octavo_io_write_arbiter : round-robin merge of CPU write ports onto one sink
// Rev 1.0
// ============================================================================
module octavo_io_write_arbiter #(
   parameter int WORD_WIDTH    = 36,
   parameter int IO_PORT_COUNT = 8,
   parameter int PORT_ID_WIDTH = 3
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [IO_PORT_COUNT-1:0]            io_wren,
   input  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
   output logic [IO_PORT_COUNT-1:0]            io_write_EF,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [WORD_WIDTH-1:0]               out_data,
   output logic [PORT_ID_WIDTH-1:0]            out_port,
   output logic [IO_PORT_COUNT-1:0]            overflow
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } out_state_t;

   localparam logic [PORT_ID_WIDTH-1:0] c_LAST_PORT = PORT_ID_WIDTH'(IO_PORT_COUNT - 1);

   out_state_t                 state_q, state_d;
   logic [IO_PORT_COUNT-1:0]   full_q, full_d;
   logic [IO_PORT_COUNT-1:0]   ovf_q, ovf_d;
   logic [WORD_WIDTH-1:0]      slot_q [IO_PORT_COUNT];
   logic [WORD_WIDTH-1:0]      slot_d [IO_PORT_COUNT];
   logic [WORD_WIDTH-1:0]      data_q, data_d;
   logic [PORT_ID_WIDTH-1:0]   port_q, port_d;
   logic [PORT_ID_WIDTH-1:0]   rr_q, rr_d;

   logic                       w_gnt_en;
   logic                       w_gnt_found;
   logic                       w_grant;
   logic [PORT_ID_WIDTH-1:0]   w_gnt_idx;

   always_comb begin
      w_gnt_en    = (state_q == S_EMPTY) || out_ready;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      // Two passes give the cyclic search: first rr_q..top, then 0..rr_q-1.
      for (int i = 0; i < IO_PORT_COUNT; i++) begin
         if (!w_gnt_found && full_q[i] && (PORT_ID_WIDTH'(i) >= rr_q)) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = PORT_ID_WIDTH'(i);
         end
      end
      for (int i = 0; i < IO_PORT_COUNT; i++) begin
         if (!w_gnt_found && full_q[i] && (PORT_ID_WIDTH'(i) < rr_q)) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = PORT_ID_WIDTH'(i);
         end
      end
      w_grant = w_gnt_en && w_gnt_found;
   end

   always_comb begin
      state_d = state_q;
      full_d  = full_q;
      ovf_d   = ovf_q;
      slot_d  = slot_q;
      data_d  = data_q;
      port_d  = port_q;
      rr_d    = rr_q;

      if (w_grant) begin
         state_d           = S_FULL;
         data_d            = slot_q[w_gnt_idx];
         port_d            = w_gnt_idx;
         rr_d              = (w_gnt_idx == c_LAST_PORT) ? '0 : w_gnt_idx + 1'b1;
         full_d[w_gnt_idx] = 1'b0;
      end else if ((state_q == S_FULL) && out_ready) begin
         state_d = S_EMPTY;
      end

      // A slot being granted this cycle may be refilled without overflow.
      for (int i = 0; i < IO_PORT_COUNT; i++) begin
         if (io_wren[i]) begin
            if (!full_q[i] || (w_grant && (w_gnt_idx == PORT_ID_WIDTH'(i)))) begin
               slot_d[i] = io_write_data[i*WORD_WIDTH +: WORD_WIDTH];
               full_d[i] = 1'b1;
            end else begin
               ovf_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_EMPTY;
         full_q  <= '0;
         ovf_q   <= '0;
         data_q  <= '0;
         port_q  <= '0;
         rr_q    <= '0;
         for (int i = 0; i < IO_PORT_COUNT; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         port_q  <= port_d;
         rr_q    <= rr_d;
         for (int i = 0; i < IO_PORT_COUNT; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign io_write_EF = full_q;
   assign out_valid   = (state_q == S_FULL);
   assign out_data    = data_q;
   assign out_port    = port_q;
   assign overflow    = ovf_q;

endmodule
`default_nettype wire
